seg_display_mux: RTL
====================

// Module: seg_display_mux
// PURPOSE
//   Multiplexed 7-segment scan driver downstream of the real-time clock core.
//   Takes a snapshot of NUM_DIGITS hex/BCD digits plus decimal-point and blank
//   masks, then drives one digit at a time. Output is the 8-bit segment bus and
//   the digit-select bus, with anti-ghost blanking and PWM brightness.
//   Snapshots are double-buffered and applied only at frame boundaries, so
//   updates never tear.
// PARAMETERS
//   NUM_DIGITS   6     digits scanned per frame (1..8)
//   SLOT_CYCLES  8333  clocks per digit slot (50 MHz, 6 digits, ~1 kHz frame); >= GUARD_CYCLES+16
//   GUARD_CYCLES 64    clocks at slot start with all digits off (anti-ghosting)
//   ACTIVE_LOW   1     1: seg/sel lit when 0 (common anode); 0: lit when 1
// PORTS
//   clk         in   1             system clock
//   reset       in   1             synchronous, active-high reset
//   digits      in   4*NUM_DIGITS  digit i value in [4i+3:4i]; digit 0 = rightmost
//   dp_mask     in   NUM_DIGITS    bit i lights decimal point of digit i
//   blank_mask  in   NUM_DIGITS    bit i forces digit i dark
//   brightness  in   4             0 = dark .. 15 = full on
//   load        in   1             1-cycle strobe: capture digits/dp/blank/brightness into shadow
//   seg         out  8             [6:0] = segments a..g, [7] = dp
//   sel         out  NUM_DIGITS    one-hot digit enable (polarity per ACTIVE_LOW)
//   frame_done  out  1             1-cycle pulse at end of last digit slot
// BEHAVIOUR
//   - Reset (sync, 1 cycle): seg/sel inactive (all 1s if ACTIVE_LOW), frame_done=0.
//     slot_cnt=0, digit idx=0, pwm=0. Shadow and active buffers are cleared:
//     digits=0, dp=0, blank=all 1s, brightness=0. Display stays dark until a load
//     is followed by a frame boundary. Reset mid-slot blanks outputs on the next edge.
//   - Shadow capture: on load=1, the inputs are registered into the shadow. Multiple
//     loads in one frame: the last wins.
//   - Frame boundary: the cycle where slot_cnt wraps from SLOT_CYCLES-1 and idx wraps
//     from NUM_DIGITS-1 to 0. Shadow copies into active. A load on that same cycle
//     reaches active at this boundary (shadow bypass).
//   - Scan: slot_cnt increments 0..SLOT_CYCLES-1 and wraps. On wrap, idx increments
//     mod NUM_DIGITS.
//   - frame_done = 1 exactly on the frame-boundary cycle (registered, one cycle).
//   - Per slot, registered outputs (1-cycle latency from counter state):
//     * slot_cnt < GUARD_CYCLES: sel all inactive, seg all inactive.
//     * otherwise: pwm (4-bit) free-runs +1/clk, reset to 0 at slot start. Digit lit
//       iff (brightness==15 || pwm < brightness) && !blank[idx].
//       brightness 0 -> never lit.
//     * lit: sel one-hot at idx; seg = decode(digits[idx]) | dp[idx]<<7.
//       Unlit: all inactive.
//   - Decode (active-high form, bit0=a..bit6=g): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D
//     7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. ACTIVE_LOW inverts seg and sel.
//   - Guarantees: never more than one sel bit active; sel and seg change together.
// TESTING
//   Tests use NUM_DIGITS=6, SLOT_CYCLES=40, GUARD_CYCLES=4, ACTIVE_LOW=1.
//   1 Reset, no load, run 2 frames -> sel=6'h3F, seg=8'hFF throughout;
//     frame_done pulses every 240 clk.
//   2 load digits=24'h123456, dp=6'b000100, blank=0, bright=15 ->
//     from next boundary, slot0 seg=~8'h7D (6), slot2 seg=~8'hE6 (4+dp);
//     sel low at bit idx only; dark first 4 clk of each slot.
//   3 bright=4 -> 4 of every 16 active-phase clocks lit;
//     bright=0 -> fully dark.
//   4 load mid-frame (slot 3), then again in slot 5 with different digits ->
//     current frame unchanged; next frame shows second load only.
//   5 load on the exact frame-boundary cycle -> new data visible in slot 0 of the
//     new frame; blank=6'b100000 keeps digit 5 dark.
//   6 assert reset mid-slot while lit -> sel=6'h3F, seg=8'hFF on the next edge;
//     idx restarts at 0 and the display stays dark until a fresh load.

Source files
------------

// File: rtl/seg_display_mux.sv
// Multiplexed 7-segment scan driver.
// Scans NUM_DIGITS digits one slot at a time. Each slot starts with a dark guard
// window and then applies PWM brightness. New data is captured into a shadow
// buffer on load and copied into the active buffer only at frame boundaries,
// so the displayed frame never tears.
module seg_display_mux #(
   parameter int NUM_DIGITS   = 6,
   parameter int SLOT_CYCLES  = 8333,
   parameter int GUARD_CYCLES = 64,
   parameter bit ACTIVE_LOW   = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   input  logic [3:0]              brightness,
   input  logic                    load,
   output logic [7:0]              seg,
   output logic [NUM_DIGITS-1:0]   sel,
   output logic                    frame_done
);

   localparam int SLOT_W = $clog2(SLOT_CYCLES);
   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
   localparam logic [SLOT_W-1:0] GUARD_END = SLOT_W'(GUARD_CYCLES);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   localparam logic [7:0]            SEG_OFF = {8{ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{ACTIVE_LOW}};

   logic [SLOT_W-1:0] slot_cnt;
   logic [IDX_W-1:0]  idx;
   logic [3:0]        pwm;

   logic [4*NUM_DIGITS-1:0] shd_digits, act_digits;
   logic [NUM_DIGITS-1:0]   shd_dp, act_dp;
   logic [NUM_DIGITS-1:0]   shd_blank, act_blank;
   logic [3:0]              shd_bright, act_bright;

   logic                  slot_wrap;
   logic                  frame_wrap;
   logic                  lit;
   logic [3:0]            cur_digit;
   logic [7:0]            seg_hi;
   logic [NUM_DIGITS-1:0] sel_hi;

   // Hex digit to segment pattern, active-high, bit0 = a .. bit6 = g.
   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   // Decide what the current counter state should show; result lands one clock later.
   always_comb begin
      slot_wrap  = (slot_cnt == SLOT_LAST);
      frame_wrap = slot_wrap && (idx == IDX_LAST);
      cur_digit  = act_digits[4*int'(idx) +: 4];
      lit        = (slot_cnt >= GUARD_END) && !act_blank[idx] &&
                   ((act_bright == 4'hF) || (pwm < act_bright));
      seg_hi     = 8'h00;
      sel_hi     = '0;
      if (lit) begin
         seg_hi = {act_dp[idx], decode(cur_digit)};
         sel_hi = NUM_DIGITS'(1) << idx;
      end
   end

   // Slot counter, digit index and PWM phase; PWM restarts at each slot start.
   always_ff @(posedge clk) begin
      if (reset) begin
         slot_cnt <= '0;
         idx      <= '0;
         pwm      <= 4'd0;
      end else begin
         if (slot_wrap) begin
            slot_cnt <= '0;
            pwm      <= 4'd0;
            idx      <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
         end else begin
            slot_cnt <= slot_cnt + SLOT_W'(1);
            pwm      <= pwm + 4'd1;
         end
      end
   end

   // Shadow buffer: the most recent load within a frame wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         shd_digits <= '0;
         shd_dp     <= '0;
         shd_blank  <= '1;
         shd_bright <= 4'd0;
      end else if (load) begin
         shd_digits <= digits;
         shd_dp     <= dp_mask;
         shd_blank  <= blank_mask;
         shd_bright <= brightness;
      end
   end

   // Active buffer updates only at the frame boundary; a load on that very cycle bypasses the shadow.
   always_ff @(posedge clk) begin
      if (reset) begin
         act_digits <= '0;
         act_dp     <= '0;
         act_blank  <= '1;
         act_bright <= 4'd0;
      end else if (frame_wrap) begin
         act_digits <= load ? digits     : shd_digits;
         act_dp     <= load ? dp_mask    : shd_dp;
         act_blank  <= load ? blank_mask : shd_blank;
         act_bright <= load ? brightness : shd_bright;
      end
   end

   // Registered outputs so seg and sel always switch on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         seg        <= SEG_OFF;
         sel        <= SEL_OFF;
         frame_done <= 1'b0;
      end else begin
         seg        <= ACTIVE_LOW ? ~seg_hi : seg_hi;
         sel        <= ACTIVE_LOW ? ~sel_hi : sel_hi;
         frame_done <= frame_wrap;
      end
   end

endmodule
